muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative signed multiply/divide unit that sits beside the ALU in the processor datapath. It takes the Y register as operand A and the bus value as operand B, and produces a 64-bit result that is written into the HI/LO registers. It uses radix-2 Booth multiplication and non-restoring division, and drives a start/busy/done handshake for the control unit.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  clock, rising edge.
clr  in  1  reset, asynchronous, active-low.
start  in  1  request; sampled only in IDLE.
op  in  1  0 = MUL, 1 = DIV; sampled together with start.
a  in  WIDTH  operand A: multiplicand or dividend, from Y.
b  in  WIDTH  operand B: multiplier or divisor, from the bus.
busy  out  1  high from the edge that accepts start until the edge that leaves DONE.
done  out  1  one-cycle pulse; hi and lo are valid while it is high.
hi  out  WIDTH  MUL: upper product word. DIV: remainder.
lo  out  WIDTH  MUL: lower product word. DIV: quotient.
div_by_zero  out  1  set with done when a DIV had b == 0; cleared on the next accepted start.

Behaviour:
- Reset (clr = 0, asynchronous): state goes to IDLE; busy, done, div_by_zero, hi, lo, the counter and all working registers go to 0. Asserting reset mid-operation aborts the operation with no done pulse.
- States: IDLE, MUL, DIV, FIX, DONE.
- Call the edge that samples start = 1 in IDLE edge 0.
- IDLE, start = 1: operands latch, counter = 0, busy = 1, div_by_zero = 0, next state is MUL or DIV according to op.
- IDLE, start = 0: hold state.
- start asserted while busy = 1 is ignored; it is not queued.
- MUL: accumulator {P[WIDTH-1:0], Q = b, q_1 = 0}. Each edge does one Booth step:
  - Q[0], q_1 = 01: P += a.
  - Q[0], q_1 = 10: P -= a.
  - Then arithmetic-shift {P, Q, q_1} right by 1.
  - Edges 1..32 perform the steps; at edge 32 the next state is DONE with {hi, lo} = {P, Q}.
  - Result is the full signed 64-bit product; no overflow is possible.
- DIV with b == 0: at edge 1 go to DONE with hi = a, lo = all-ones, div_by_zero = 1.
- DIV with b != 0: run non-restoring division on |a| and |b| as unsigned magnitudes, one quotient bit per edge over edges 1..32. Then go to FIX.
- FIX (edge 33):
  - If the partial remainder is negative, restore it by adding |b|.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Negate as required (two's complement, truncate toward zero); then go to DONE.
- DIV overflow case 0x80000000 / 0xFFFFFFFF yields lo = 0x80000000, hi = 0 from natural wrap, with no flag.
- DONE: done = 1 for exactly one cycle, then IDLE with busy = 0 on the next edge. start is not sampled while in DONE.
- Latency: done is high in the cycle after edge 32 (MUL), edge 33 (DIV), or edge 1 (divide by zero).
- hi, lo and div_by_zero hold their last values until the next DONE, or until reset. div_by_zero is the exception: it clears on an accepted start.

Decomposition:
- muldiv_pkg holds: the state enum (IDLE, MUL, DIV, FIX, DONE), OP_MUL = 1'b0, OP_DIV = 1'b1, and default WIDTH / CNT_W constants.
- One combinational sub-module, muldiv_nrdiv_step, computes one non-restoring step: given remainder, quotient and divisor magnitude, it returns the next remainder and quotient. The Booth step stays inline.

Test Plan:
- Reset, then idle 5 cycles -> busy = 0, done = 0, hi = lo = 0, div_by_zero = 0.
- MUL a = 7, b = 0xFFFFFFFD (-3) -> done exactly 33 cycles after start, with hi = 0xFFFFFFFF and lo = 0xFFFFFFEB. Also MUL 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0.
- DIV a = 0xFFFFFFEF (-17), b = 5 -> done 34 cycles after start, with lo = 0xFFFFFFFD and hi = 0xFFFFFFFE. Also DIV 17 / -5 -> lo = 0xFFFFFFFD, hi = 2.
- DIV a = 0x1234, b = 0 -> done 2 cycles after start, with hi = 0x1234, lo = 0xFFFFFFFF, div_by_zero = 1. A following MUL start clears div_by_zero.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0, div_by_zero = 0.
- Pulse start again at cycle 10 of a MUL -> ignored, single done with the original result. Then clr low at cycle 15 of a new DIV -> immediate IDLE, outputs 0, no done pulse. Then a new start completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

endpackage

// File: rtl/muldiv_nrdiv_step.sv
// One non-restoring division step on unsigned magnitudes.
module muldiv_nrdiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH+1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH+1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dvs_ext;

    // Two guard bits: the shifted remainder spans [-2*dvs, 2*dvs).
    assign shifted = {rem[WIDTH:0], quo[WIDTH-1]};
    assign dvs_ext = {2'b00, dvs};

    assign rem_nxt = rem[WIDTH+1] ? shifted + dvs_ext
                                  : shifted - dvs_ext;
    assign quo_nxt = {quo[WIDTH-2:0], ~rem_nxt[WIDTH+1]};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring)
// unit producing a HI/LO result pair with a start/busy/done handshake.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q;
    logic             q1;
    logic [WIDTH+1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic             qneg;
    logic             rneg;

    logic             last;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   p_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH+1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] r_mag;

    assign last  = (cnt == CNT_W'(WIDTH - 1));
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    // P carries one extra sign bit so that P - (-2^(W-1)) cannot overflow.
    assign a_ext = {a_r[WIDTH-1], a_r};

    always_comb begin
        sum = p;
        case ({q[0], q1})
            2'b01:   sum = p + a_ext;
            2'b10:   sum = p - a_ext;
            default: sum = p;
        endcase
    end

    assign p_nxt = {sum[WIDTH], sum[WIDTH:1]};
    assign q_nxt = {sum[0], q[WIDTH-1:1]};

    muldiv_nrdiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem     (rem),
        .quo     (q),
        .dvs     (dvs),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // The final remainder is below dvs, so low-word wrap suffices.
    assign r_mag = rem[WIDTH-1:0] + (rem[WIDTH+1] ? dvs : '0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= S_IDLE;
            cnt         <= '0;
            a_r         <= '0;
            p           <= '0;
            q           <= '0;
            q1          <= 1'b0;
            rem         <= '0;
            dvs         <= '0;
            qneg        <= 1'b0;
            rneg        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r         <= a;
                        p           <= '0;
                        q           <= (op == OP_MUL) ? b : a_mag;
                        q1          <= 1'b0;
                        rem         <= '0;
                        dvs         <= b_mag;
                        qneg        <= a[WIDTH-1] ^ b[WIDTH-1];
                        rneg        <= a[WIDTH-1];
                        cnt         <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        state       <= (op == OP_MUL) ? S_MUL : S_DIV;
                    end
                end
                S_MUL: begin
                    p   <= p_nxt;
                    q   <= q_nxt;
                    q1  <= q[0];
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        hi    <= p_nxt[WIDTH-1:0];
                        lo    <= q_nxt;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (dvs == '0) begin
                        hi          <= a_r;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        rem <= rem_nxt;
                        q   <= quo_nxt;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    hi    <= rneg ? -r_mag : r_mag;
                    lo    <= qneg ? -q : q;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: MUL/DIV results, latency and handshake.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    logic        clk;
    logic        clr;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int   checks;
    int   passed;
    exp_t sb[$];

    muldiv_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic o, input logic [31:0] x,
                                   input logic [31:0] y);
        exp_t e;
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] pr;
        int ix;
        int iy;
        int qq;
        int rr;
        e.dbz = 1'b0;
        if (o == 1'b0) begin
            sx = 64'($signed(x));
            sy = 64'($signed(y));
            pr = sx * sy;
            e.hi = pr[63:32];
            e.lo = pr[31:0];
            e.lat = 33;
        end else if (y == 32'h0) begin
            e.hi = x;
            e.lo = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
            e.lat = 2;
        end else begin
            ix = $signed(x);
            iy = $signed(y);
            qq = ix / iy;
            rr = ix % iy;
            e.hi = rr;
            e.lo = qq;
            e.lat = 34;
        end
        return e;
    endfunction

    task automatic launch(input logic o, input logic [31:0] x,
                          input logic [31:0] y);
        @(posedge clk);
        #1;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        clr = 1'b0;
        start = 1'b0;
        op = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else passed++;
        checks++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
        else passed++;
        checks++;
        if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo got %h want 0", {hi, lo});
        else passed++;
        checks++;
        if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", div_by_zero);
        else passed++;
    endtask

    task automatic run_vec(input string nm, input logic o,
                           input logic [31:0] x, input logic [31:0] y);
        int n;
        exp_t e;
        launch(o, x, y);
        checks++;
        if (busy !== 1'b1) $display("FAIL %s busy got %b want 1", nm, busy);
        else passed++;
        wait_done(n);
        e = sb.pop_front();
        checks++;
        if (n !== e.lat) $display("FAIL %s latency got %0d want %0d", nm, n, e.lat);
        else passed++;
        checks++;
        if (hi !== e.hi) $display("FAIL %s hi got %h want %h", nm, hi, e.hi);
        else passed++;
        checks++;
        if (lo !== e.lo) $display("FAIL %s lo got %h want %h", nm, lo, e.lo);
        else passed++;
        checks++;
        if (div_by_zero !== e.dbz) $display("FAIL %s dbz got %b want %b", nm, div_by_zero, e.dbz);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy} !== 2'b00) $display("FAIL %s after_done got %b want 00", nm, {done, busy});
        else passed++;
    endtask

    task automatic test_mul;
        logic [31:0] x;
        logic [31:0] y;
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, dbz: 1'b0, lat: 33});
        run_vec("mul_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD);
        sb.push_back('{hi: 32'h4000_0000, lo: 32'h0, dbz: 1'b0, lat: 33});
        run_vec("mul_min_sq", 1'b0, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 4; i++) begin
            x = $urandom;
            y = $urandom;
            sb.push_back(model(1'b0, x, y));
            run_vec("mul_rand", 1'b0, x, y);
        end
    endtask

    task automatic test_div;
        logic [31:0] x;
        logic [31:0] y;
        sb.push_back('{hi: 32'hFFFF_FFFE, lo: 32'hFFFF_FFFD, dbz: 1'b0, lat: 34});
        run_vec("div_-17/5", 1'b1, 32'hFFFF_FFEF, 32'd5);
        sb.push_back('{hi: 32'd2, lo: 32'hFFFF_FFFD, dbz: 1'b0, lat: 34});
        run_vec("div_17/-5", 1'b1, 32'd17, 32'hFFFF_FFFB);
        for (int i = 0; i < 4; i++) begin
            x = $urandom;
            y = (i < 2) ? 32'($urandom_range(1, 999)) : $urandom;
            if (y == 32'h0) y = 32'd3;
            sb.push_back(model(1'b1, x, y));
            run_vec("div_rand", 1'b1, x, y);
        end
    endtask

    task automatic test_div_zero;
        int n;
        exp_t e;
        sb.push_back('{hi: 32'h1234, lo: 32'hFFFF_FFFF, dbz: 1'b1, lat: 2});
        run_vec("div_zero", 1'b1, 32'h1234, 32'h0);
        sb.push_back(model(1'b0, 32'd9, 32'd11));
        launch(1'b0, 32'd9, 32'd11);
        checks++;
        if (div_by_zero !== 1'b0) $display("FAIL dbz_clear got %b want 0", div_by_zero);
        else passed++;
        wait_done(n);
        e = sb.pop_front();
        checks++;
        if ({n, hi, lo} !== {e.lat, e.hi, e.lo})
            $display("FAIL dbz_next_mul got %0d %h %h want %0d %h %h", n, hi, lo, e.lat, e.hi, e.lo);
        else passed++;
    endtask

    task automatic test_div_overflow;
        sb.push_back('{hi: 32'h0, lo: 32'h8000_0000, dbz: 1'b0, lat: 34});
        run_vec("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_ignore_restart;
        int n;
        int dones;
        int lat;
        logic [31:0] h;
        logic [31:0] l;
        exp_t e;
        sb.push_back(model(1'b0, 32'h0001_2345, 32'hFFFF_6789));
        launch(1'b0, 32'h0001_2345, 32'hFFFF_6789);
        n = 1;
        dones = 0;
        lat = 0;
        h = '0;
        l = '0;
        while (n < 80) begin
            if (n == 9) begin
                start = 1'b1;
                op = 1'b1;
                a = 32'd100;
                b = 32'd3;
            end
            if (n == 10) start = 1'b0;
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    lat = n;
                    h = hi;
                    l = lo;
                end
            end
        end
        e = sb.pop_front();
        checks++;
        if (dones !== 1) $display("FAIL restart_dones got %0d want 1", dones);
        else passed++;
        checks++;
        if (lat !== e.lat) $display("FAIL restart_latency got %0d want %0d", lat, e.lat);
        else passed++;
        checks++;
        if ({h, l} !== {e.hi, e.lo}) $display("FAIL restart_result got %h want %h", {h, l}, {e.hi, e.lo});
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL restart_idle got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_abort;
        int dones;
        launch(1'b1, 32'd1000, 32'd7);
        repeat (14) @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000)
            $display("FAIL abort_flags got %b want 000", {busy, done, div_by_zero});
        else passed++;
        checks++;
        if ({hi, lo} !== 64'h0) $display("FAIL abort_hilo got %h want 0", {hi, lo});
        else passed++;
        dones = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        clr = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) $display("FAIL abort_no_done got %0d want 0", dones);
        else passed++;
        sb.push_back(model(1'b1, 32'hFFFF_FC18, 32'd7));
        run_vec("after_abort", 1'b1, 32'hFFFF_FC18, 32'd7);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_div_overflow();
        test_ignore_restart();
        test_abort();
        checks++;
        if (sb.size() !== 0) $display("FAIL scoreboard_left got %0d want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
